// File: rtl/vigna_bus_arbiter_pkg.sv
// Shared types and constants for the vigna instruction/data bus arbiter.
// State encoding, grant identifiers and bus widths live here so every file agrees.
package vigna_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    localparam logic [STRB_W-1:0] WSTRB_READ = 4'h0;

endpackage

// File: rtl/vigna_bus_arbiter_if.sv
// One valid/ready memory port: the requester drives the master side,
// the responder drives ready and read data on the slave side.
interface vigna_bus_arbiter_if;
    import vigna_bus_pkg::*;

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );

endinterface

// File: rtl/vigna_bus_arbiter_rr_pick.sv
// Combinational two-way grant between the fetch and data ports.
// On conflict it alternates against last_grant, or always favours data when round robin is off.
module vigna_rr_pick
    import vigna_bus_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic i_valid,
    input  logic d_valid,
    input  gnt_t last_grant,
    output gnt_t grant
);

    always_comb begin
        grant = GNT_I;
        if (i_valid && d_valid) begin
            if (ROUND_ROBIN != 0) begin
                grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
            end else begin
                grant = GNT_D;
            end
        end else if (d_valid) begin
            grant = GNT_D;
        end
    end

endmodule

// File: rtl/vigna_bus_arbiter.sv
// Merges the vigna core's fetch and load/store ports onto one memory bus,
// one transaction at a time, and holds each port's last read data between transactions.
module vigna_bus_arbiter
    import vigna_bus_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input logic                 clk,
    input logic                 resetn,
    vigna_bus_arbiter_if.slave  ibus,
    vigna_bus_arbiter_if.slave  dbus,
    vigna_bus_arbiter_if.master mbus
);

    state_t            state_q, state_d;
    gnt_t              last_grant_q, last_grant_d;
    gnt_t              gnt_q, gnt_d;
    gnt_t              pick;
    logic              m_valid_q, m_valid_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [STRB_W-1:0] m_wstrb_q, m_wstrb_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    // The fetch port never writes; its write fields exist only because both ports share one interface type.
    logic unused_ifetch_wr;
    assign unused_ifetch_wr = ^{ibus.wdata, ibus.wstrb};

    vigna_rr_pick #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_pick (
        .i_valid    (ibus.valid),
        .d_valid    (dbus.valid),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
            gnt_q        <= GNT_I;
            m_valid_q    <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= WSTRB_READ;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            m_valid_q    <= m_valid_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_wstrb_q    <= m_wstrb_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        m_valid_d    = m_valid_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_wstrb_d    = m_wstrb_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (ibus.valid || dbus.valid) begin
                    state_d      = REQ;
                    gnt_d        = pick;
                    last_grant_d = pick;
                    m_valid_d    = 1'b1;
                    if (pick == GNT_D) begin
                        m_addr_d  = dbus.addr;
                        m_wdata_d = dbus.wdata;
                        m_wstrb_d = dbus.wstrb;
                    end else begin
                        m_addr_d  = ibus.addr;
                        m_wdata_d = '0;
                        m_wstrb_d = WSTRB_READ;
                    end
                end
            end
            REQ: begin
                if (mbus.ready) begin
                    state_d   = RESP;
                    m_valid_d = 1'b0;
                    m_wstrb_d = WSTRB_READ;
                    if (gnt_q == GNT_I) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = mbus.rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (m_wstrb_q == WSTRB_READ) begin
                            d_rdata_d = mbus.rdata;
                        end
                    end
                end
            end
            // Requesters still hold valid here, so nothing is sampled until IDLE.
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mbus.valid = m_valid_q;
    assign mbus.addr  = m_addr_q;
    assign mbus.wdata = m_wdata_q;
    assign mbus.wstrb = m_wstrb_q;
    assign ibus.ready = i_ready_q;
    assign ibus.rdata = i_rdata_q;
    assign dbus.ready = d_ready_q;
    assign dbus.rdata = d_rdata_q;

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Directed bench for vigna_bus_arbiter: one round-robin and one fixed-priority instance,
// memory responses driven step by step with hand-computed expectations.
module tb_vigna_bus_arbiter;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vigna_bus_arbiter_if i1();
    vigna_bus_arbiter_if d1();
    vigna_bus_arbiter_if m1();
    vigna_bus_arbiter_if i0();
    vigna_bus_arbiter_if d0();
    vigna_bus_arbiter_if m0();

    vigna_bus_arbiter #(.ROUND_ROBIN(1)) u_rr (
        .clk    (clk),
        .resetn (resetn),
        .ibus   (i1),
        .dbus   (d1),
        .mbus   (m1)
    );

    vigna_bus_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .clk    (clk),
        .resetn (resetn),
        .ibus   (i0),
        .dbus   (d0),
        .mbus   (m0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        i1.valid = 1'b0; i1.addr = '0; i1.wdata = '0; i1.wstrb = '0;
        d1.valid = 1'b0; d1.addr = '0; d1.wdata = '0; d1.wstrb = '0;
        m1.ready = 1'b0; m1.rdata = '0;
        i0.valid = 1'b0; i0.addr = '0; i0.wdata = '0; i0.wstrb = '0;
        d0.valid = 1'b0; d0.addr = '0; d0.wdata = '0; d0.wstrb = '0;
        m0.ready = 1'b0; m0.rdata = '0;
        repeat (2) tick();

        chk1("rst_i_ready", i1.ready, 1'b0);
        chk1("rst_d_ready", d1.ready, 1'b0);
        chk1("rst_m_valid", m1.valid, 1'b0);
        chk("rst_m_addr", m1.addr, 32'h0);
        chk("rst_m_wdata", m1.wdata, 32'h0);
        chk("rst_m_wstrb", 32'(m1.wstrb), 32'h0);
        chk("rst_i_rdata", i1.rdata, 32'h0);
        chk("rst_d_rdata", d1.rdata, 32'h0);
        chk1("rst_fp_m_valid", m0.valid, 1'b0);
        resetn = 1'b1;
        tick();

        // Fetch with two wait states
        i1.valid = 1'b1; i1.addr = 32'h100;
        tick();
        chk1("t1_m_valid", m1.valid, 1'b1);
        chk("t1_m_addr", m1.addr, 32'h100);
        chk("t1_m_wstrb", 32'(m1.wstrb), 32'h0);
        chk("t1_m_wdata", m1.wdata, 32'h0);
        chk1("t1_i_ready_early", i1.ready, 1'b0);
        repeat (2) begin
            tick();
            chk1("t1_wait_m_valid", m1.valid, 1'b1);
            chk("t1_wait_m_addr", m1.addr, 32'h100);
        end
        m1.ready = 1'b1; m1.rdata = 32'h0000_0013;
        tick();
        chk1("t1_i_ready", i1.ready, 1'b1);
        chk1("t1_d_ready", d1.ready, 1'b0);
        chk1("t1_m_valid_drop", m1.valid, 1'b0);
        chk("t1_i_rdata", i1.rdata, 32'h13);
        m1.ready = 1'b0; m1.rdata = 32'hFFFF_FFFF;
        tick();
        chk1("t1_i_ready_pulse", i1.ready, 1'b0);
        chk1("t5_no_dup_m_valid", m1.valid, 1'b0);
        i1.valid = 1'b0;
        tick();
        chk1("t1_idle_m_valid", m1.valid, 1'b0);
        chk("t1_i_rdata_hold", i1.rdata, 32'h13);

        // Store, zero wait states
        d1.valid = 1'b1; d1.addr = 32'h2000; d1.wdata = 32'hDEAD_BEEF; d1.wstrb = 4'hF;
        tick();
        chk1("t2_m_valid", m1.valid, 1'b1);
        chk("t2_m_addr", m1.addr, 32'h2000);
        chk("t2_m_wdata", m1.wdata, 32'hDEAD_BEEF);
        chk("t2_m_wstrb", 32'(m1.wstrb), 32'hF);
        m1.ready = 1'b1; m1.rdata = 32'h55AA_55AA;
        tick();
        chk1("t2_d_ready", d1.ready, 1'b1);
        chk1("t2_i_ready", i1.ready, 1'b0);
        chk("t2_d_rdata_unchanged", d1.rdata, 32'h0);
        chk("t2_m_wstrb_clr", 32'(m1.wstrb), 32'h0);
        m1.ready = 1'b0;
        tick();
        chk1("t2_d_ready_pulse", d1.ready, 1'b0);
        d1.valid = 1'b0;
        tick();

        // Data read latches d_rdata only
        d1.valid = 1'b1; d1.addr = 32'h3000; d1.wdata = 32'h0; d1.wstrb = 4'h0;
        tick();
        chk("t2b_m_wstrb", 32'(m1.wstrb), 32'h0);
        m1.ready = 1'b1; m1.rdata = 32'hCAFE_F00D;
        tick();
        chk1("t2b_d_ready", d1.ready, 1'b1);
        chk("t2b_d_rdata", d1.rdata, 32'hCAFE_F00D);
        chk("t2b_i_rdata_hold", i1.rdata, 32'h13);
        m1.ready = 1'b0;
        tick();
        d1.valid = 1'b0;
        tick();

        // Round-robin conflicts starting from reset (last_grant = I)
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        i1.valid = 1'b1; i1.addr = 32'h400;
        d1.valid = 1'b1; d1.addr = 32'h800;
        tick();
        chk("t3_first_d", m1.addr, 32'h800);
        m1.ready = 1'b1; m1.rdata = 32'h1111_1111;
        tick();
        chk1("t3_d_ready1", d1.ready, 1'b1);
        chk1("t3_i_ready1", i1.ready, 1'b0);
        chk("t3_d_rdata1", d1.rdata, 32'h1111_1111);
        m1.ready = 1'b0; d1.addr = 32'h804;
        tick();
        chk1("t3_resp_no_m_valid", m1.valid, 1'b0);
        tick();
        chk("t3_second_i", m1.addr, 32'h400);
        m1.ready = 1'b1; m1.rdata = 32'h2222_2222;
        tick();
        chk1("t3_i_ready2", i1.ready, 1'b1);
        chk1("t3_d_ready2", d1.ready, 1'b0);
        chk("t3_i_rdata2", i1.rdata, 32'h2222_2222);
        m1.ready = 1'b0; i1.addr = 32'h408;
        tick();
        tick();
        chk("t3_third_d", m1.addr, 32'h804);
        m1.ready = 1'b1; m1.rdata = 32'h3333_3333;
        tick();
        chk1("t3_d_ready3", d1.ready, 1'b1);
        chk("t3_d_rdata3", d1.rdata, 32'h3333_3333);
        m1.ready = 1'b0; d1.addr = 32'h808;
        tick();
        tick();
        chk("t3_fourth_i", m1.addr, 32'h408);
        m1.ready = 1'b1; m1.rdata = 32'h4444_4444;
        tick();
        chk1("t3_i_ready4", i1.ready, 1'b1);
        chk("t3_i_rdata4", i1.rdata, 32'h4444_4444);
        m1.ready = 1'b0; i1.valid = 1'b0;
        tick();
        tick();
        chk("t3_fifth_d", m1.addr, 32'h808);
        m1.ready = 1'b1; m1.rdata = 32'h5555_5555;
        tick();
        chk1("t3_d_ready5", d1.ready, 1'b1);
        m1.ready = 1'b0; d1.valid = 1'b0;
        tick();
        tick();

        // Fixed priority: data wins every conflict
        i0.valid = 1'b1; i0.addr = 32'h500;
        d0.valid = 1'b1; d0.addr = 32'h600; d0.wdata = 32'hA5A5_A5A5; d0.wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_d_wins_addr", m0.addr, 32'(32'h600 + 4 * k));
            chk1("t4_m_valid", m0.valid, 1'b1);
            m0.ready = 1'b1; m0.rdata = 32'h6666_6666;
            tick();
            chk1("t4_d_ready", d0.ready, 1'b1);
            chk1("t4_i_ready", i0.ready, 1'b0);
            m0.ready = 1'b0;
            if (k == 3) d0.valid = 1'b0;
            else d0.addr = 32'(32'h600 + 4 * (k + 1));
            tick();
        end
        tick();
        chk("t4_i_addr", m0.addr, 32'h500);
        chk("t4_i_wstrb", 32'(m0.wstrb), 32'h0);
        chk("t4_i_wdata", m0.wdata, 32'h0);
        m0.ready = 1'b1; m0.rdata = 32'h0000_0077;
        tick();
        chk1("t4_i_ready_last", i0.ready, 1'b1);
        chk("t4_i_rdata", i0.rdata, 32'h77);
        chk("t4_d_rdata_stores", d0.rdata, 32'h0);
        m0.ready = 1'b0; i0.valid = 1'b0;
        tick();

        // m_ready outside REQ is ignored
        m1.ready = 1'b1; m1.rdata = 32'h0000_0099;
        tick();
        chk1("stray_i_ready", i1.ready, 1'b0);
        chk1("stray_d_ready", d1.ready, 1'b0);
        chk("stray_d_rdata", d1.rdata, 32'h5555_5555);
        chk("stray_i_rdata", i1.rdata, 32'h4444_4444);
        m1.ready = 1'b0;
        tick();

        // Reset while a request is outstanding
        i1.valid = 1'b1; i1.addr = 32'h700;
        tick();
        chk1("t6_m_valid", m1.valid, 1'b1);
        resetn = 1'b0; m1.ready = 1'b1; m1.rdata = 32'h0000_0088;
        tick();
        chk1("t6_m_valid_clr", m1.valid, 1'b0);
        chk1("t6_no_i_ready", i1.ready, 1'b0);
        chk("t6_m_addr_clr", m1.addr, 32'h0);
        chk("t6_i_rdata_clr", i1.rdata, 32'h0);
        chk("t6_d_rdata_clr", d1.rdata, 32'h0);
        resetn = 1'b1; m1.ready = 1'b0; i1.valid = 1'b0;
        tick();
        chk1("t6_idle_no_ready", i1.ready, 1'b0);
        chk1("t6_idle_m_valid", m1.valid, 1'b0);
        i1.valid = 1'b1; i1.addr = 32'h704;
        tick();
        chk1("t6_restart_m_valid", m1.valid, 1'b1);
        chk("t6_restart_addr", m1.addr, 32'h704);
        m1.ready = 1'b1; m1.rdata = 32'h0000_ABCD;
        tick();
        chk1("t6_restart_i_ready", i1.ready, 1'b1);
        chk("t6_restart_i_rdata", i1.rdata, 32'hABCD);
        m1.ready = 1'b0; i1.valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
